// File: rtl/pll_phase_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pll_phase_sequencer
// Description : Drives PLL dynamic phase-shift commands over an Avalon-MM
//               reconfig port and tracks the net signed phase position.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_phase_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int POLL_GAP       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_steps,
    input  logic [4:0]  cmd_cntsel,
    input  logic        cmd_up,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] phase_pos,
    output logic [5:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam logic [5:0] c_ADDR_MODE   = 6'h00;
    localparam logic [5:0] c_ADDR_STATUS = 6'h01;
    localparam logic [5:0] c_ADDR_START  = 6'h02;
    localparam logic [5:0] c_ADDR_DPS    = 6'h06;

    localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_MAX  = c_TMR_W'(TIMEOUT_CYCLES);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(POLL_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_MODE  = 3'd1,
        S_WR_DPS   = 3'd2,
        S_WR_START = 3'd3,
        S_POLL_GAP = 3'd4,
        S_POLL_RD  = 3'd5,
        S_FINISH   = 3'd6
    } state_t;

    state_t             r_state;
    logic [15:0]        r_steps;
    logic [4:0]         r_cntsel;
    logic               r_up;
    logic               r_mode_set;
    logic [c_TMR_W-1:0] r_tmr;
    logic [c_GAP_W-1:0] r_gap;
    logic               r_done;
    logic               r_err;
    logic [15:0]        r_pos;
    logic [5:0]         r_addr;
    logic               r_rd;
    logic               r_wr;
    logic [31:0]        r_wdata;

    logic        w_timeout;
    logic [31:0] w_dps;
    logic [15:0] w_next_pos;
    logic        w_unused_rd;

    assign w_timeout   = (r_tmr == c_TMR_MAX);
    assign w_dps       = {10'b0, r_up, r_cntsel, r_steps};
    assign w_next_pos  = r_up ? (r_pos + r_steps) : (r_pos - r_steps);
    assign w_unused_rd = ^avm_readdata[31:1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_steps    <= '0;
            r_cntsel   <= '0;
            r_up       <= 1'b0;
            r_mode_set <= 1'b0;
            r_tmr      <= '0;
            r_gap      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_pos      <= '0;
            r_addr     <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_wdata    <= '0;
        end else begin
            r_done <= 1'b0;
            // Timer saturates so a long stalled read cannot wrap it back under the limit
            if ((r_state == S_POLL_GAP || r_state == S_POLL_RD) && !w_timeout) begin
                r_tmr <= r_tmr + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_steps  <= cmd_steps;
                        r_cntsel <= cmd_cntsel;
                        r_up     <= cmd_up;
                        if (cmd_steps == 16'd0) begin
                            r_done  <= 1'b1;
                            r_err   <= 1'b0;
                            r_state <= S_FINISH;
                        end else if (!r_mode_set) begin
                            r_wr    <= 1'b1;
                            r_addr  <= c_ADDR_MODE;
                            r_wdata <= 32'd1;
                            r_state <= S_WR_MODE;
                        end else begin
                            r_wr    <= 1'b1;
                            r_addr  <= c_ADDR_DPS;
                            r_wdata <= {10'b0, cmd_up, cmd_cntsel, cmd_steps};
                            r_state <= S_WR_DPS;
                        end
                    end
                end
                S_WR_MODE: begin
                    if (!avm_waitrequest) begin
                        r_mode_set <= 1'b1;
                        r_addr     <= c_ADDR_DPS;
                        r_wdata    <= w_dps;
                        r_state    <= S_WR_DPS;
                    end
                end
                S_WR_DPS: begin
                    if (!avm_waitrequest) begin
                        r_addr  <= c_ADDR_START;
                        r_wdata <= 32'd1;
                        r_state <= S_WR_START;
                    end
                end
                S_WR_START: begin
                    if (!avm_waitrequest) begin
                        r_wr    <= 1'b0;
                        r_tmr   <= '0;
                        r_gap   <= '0;
                        r_state <= S_POLL_GAP;
                    end
                end
                S_POLL_GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_gap <= '0;
                        if (w_timeout) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_rd    <= 1'b1;
                            r_addr  <= c_ADDR_STATUS;
                            r_state <= S_POLL_RD;
                        end
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                S_POLL_RD: begin
                    if (!avm_waitrequest) begin
                        r_rd <= 1'b0;
                        if (avm_readdata[0]) begin
                            r_pos   <= w_next_pos;
                            r_err   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else if (w_timeout) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_state <= S_POLL_GAP;
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign err           = r_err;
    assign phase_pos     = r_pos;
    assign avm_address   = r_addr;
    assign avm_read      = r_rd;
    assign avm_write     = r_wr;
    assign avm_writedata = r_wdata;

endmodule
`default_nettype wire

// File: doc/pll_phase_sequencer.md
PLL_PHASE_SEQUENCER -- requirements
Module: pll_phase_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 4096, max cycles spent polling for reconfig done before abort.
REQ-002 Parameter: POLL_GAP, default 4, idle cycles between consecutive status reads.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-low.
REQ-005 cmd_valid  input  1  phase-shift command present.
REQ-006 cmd_ready  output  1  block accepts a command this cycle.
REQ-007 cmd_steps  input  16  number of phase steps requested.
REQ-008 cmd_cntsel  input  5  PLL output counter select.
REQ-009 cmd_up  input  1  1 = shift later, 0 = shift earlier.
REQ-010 busy  output  1  command in progress.
REQ-011 done  output  1  one-cycle pulse on command completion.
REQ-012 err  output  1  sticky timeout flag.
REQ-013 phase_pos  output  16  signed net phase-step position.
REQ-014 avm_address  output  6  reconfig slave word address.
REQ-015 avm_read  output  1  read strobe.
REQ-016 avm_write  output  1  write strobe.
REQ-017 avm_writedata  output  32  write data.
REQ-018 avm_readdata  input  32  read data, valid in the cycle avm_waitrequest is low during a read.
REQ-019 avm_waitrequest  input  1  slave stall.

Function
REQ-020 Register map used SHALL be: 0x00 mode, 0x01 status (bit0 = done), 0x02 start, 0x06 dynamic phase shift (DPS).
REQ-021 DPS word SHALL be {10'b0, cmd_up, cmd_cntsel, cmd_steps} (bits [15:0] steps, [20:16] cntsel, [21] up).
REQ-022 cmd_ready SHALL be high only in IDLE; a command is accepted on cmd_valid && cmd_ready and its fields captured that cycle.
REQ-023 States: IDLE, WR_MODE, WR_DPS, WR_START, POLL_GAP, POLL_RD, FINISH.
REQ-024 IDLE -> WR_MODE on accept if mode not yet set since reset, else -> WR_DPS.
REQ-025 WR_MODE writes 0x00 <= 1 (polling mode), sets mode-set flag, -> WR_DPS.
REQ-026 WR_DPS writes 0x06 <= DPS word, -> WR_START; WR_START writes 0x02 <= 1, clears poll timer, -> POLL_GAP.
REQ-027 POLL_GAP waits POLL_GAP cycles, -> POLL_RD; POLL_RD reads 0x01: bit0=1 -> FINISH, bit0=0 -> POLL_GAP.
REQ-028 Poll timer SHALL count every cycle in POLL_GAP/POLL_RD; reaching TIMEOUT_CYCLES SHALL abort at the next transaction boundary: err <= 1, no phase_pos update, done pulse, -> IDLE.
REQ-029 FINISH: phase_pos <= phase_pos + steps (up) or - steps (down), 16-bit two's-complement wrap, done pulse, err <= 0, -> IDLE.
REQ-030 Avalon: strobe, address, data SHALL hold stable while avm_waitrequest high; transfer completes in the cycle waitrequest is sampled low; strobe drops the following cycle unless a new transfer starts.
REQ-031 avm_read and avm_write SHALL never be high together; at most one outstanding transfer.
REQ-032 cmd_steps = 0 SHALL complete with no bus traffic: done pulse the cycle after accept, phase_pos unchanged, err cleared.
REQ-033 busy SHALL equal (state != IDLE); done and cmd_ready SHALL never be high together.
REQ-034 cmd_valid while busy SHALL be ignored (not queued).

Reset
REQ-035 reset low SHALL, at the next edge, force IDLE regardless of state, abandon any bus transfer, and clear mode-set flag.
REQ-036 Reset values: cmd_ready 1 (after reset released), busy 0, done 0, err 0, phase_pos 0, avm_read 0, avm_write 0, avm_address 0, avm_writedata 0.

Verification
REQ-037 First command steps=5, cntsel=2, up=1, slave waitrequest 0, status done on 2nd read -> writes 0x00<=1, 0x06<=0x00220005, 0x02<=1, two reads of 0x01, done pulse, phase_pos=5.
REQ-038 Second command steps=3, up=0 -> no mode write, DPS 0x00020003 (cntsel 2), phase_pos=2.
REQ-039 waitrequest held high 7 cycles on DPS write -> address/data/strobe stable all 7 cycles, single transfer completes.
REQ-040 Status never done, TIMEOUT_CYCLES=64 -> err=1, done pulse, phase_pos unchanged; next good command clears err.
REQ-041 phase_pos=0x7FFF, command up steps=1 -> phase_pos=0x8000; steps=0 command -> done 1 cycle after accept, no strobes.
REQ-042 reset low during POLL_RD with waitrequest high -> next edge avm_read=0, busy=0, all outputs at reset values; next command re-issues mode write.
